x_200_mod_4051_loader: RTL and testbench

Sequential front end for the 200-bit mod-4051 reducer. It assembles a 200-bit operand from a 32-bit valid/ready word stream and drives it to the reducer. It waits a configurable number of cycles for the reducer to settle, then captures the 12-bit residue and presents it on a valid/ready result port. Operands are processed one at a time, with no overlap.

---
 rtl/x_200_mod_4051_loader.sv | 120 ++++++++++++
 tb/tb_x_200_mod_4051_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_200_mod_4051_loader.sv
// Front end for the 200-bit mod-4051 reducer: packs a 32-bit word stream into X_OUT,
// waits MOD_LAT+1 cycles for the reducer, then captures R_IN and hands it out.
module x_200_mod_4051_loader #(
    parameter int unsigned MOD_LAT = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [32:1]  IN_DATA,
    input  logic         IN_VALID,
    input  logic         IN_LAST,
    output logic         IN_READY,
    output logic [200:1] X_OUT,
    input  logic [12:1]  R_IN,
    output logic [12:1]  R_OUT,
    output logic         R_VALID,
    input  logic         R_READY,
    output logic         ERR
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_EVAL,
        ST_HOLD
    } state_t;

    localparam logic [3:0] LAT = 4'(MOD_LAT);

    state_t         state_reg, state_next;
    logic [2:0]     k_reg, k_next;
    logic [3:0]     wait_reg, wait_next;
    logic [200:1]   x_reg, x_next;
    logic [12:1]    r_reg, r_next;
    logic           err_reg, err_next;
    logic           accept;

    assign accept = (state_reg == ST_LOAD) && IN_VALID;

    // Beat 0 loads word 0 and zeroes everything above it, so short operands zero-extend.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_word
            assign x_next[32*gi+32 : 32*gi+1] =
                (k_reg == 3'(gi)) ? IN_DATA :
                (k_reg == 3'd0)   ? 32'd0   :
                                    x_reg[32*gi+32 : 32*gi+1];
        end
    endgenerate

    // Only 8 bits of the seventh word fit in the 200-bit operand.
    assign x_next[200:193] = (k_reg == 3'd6) ? IN_DATA[8:1] :
                             (k_reg == 3'd0) ? 8'd0         :
                                               x_reg[200:193];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_LOAD;
            k_reg     <= 3'd0;
            wait_reg  <= 4'd0;
            x_reg     <= '0;
            r_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            wait_reg  <= wait_next;
            r_reg     <= r_next;
            err_reg   <= err_next;
            if (accept) begin
                x_reg <= x_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        wait_next  = wait_reg;
        r_next     = r_reg;
        err_next   = 1'b0;
        IN_READY   = 1'b0;
        R_VALID    = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    if (IN_LAST || (k_reg == 3'd6)) begin
                        state_next = ST_EVAL;
                        k_next     = 3'd0;
                        wait_next  = LAT;
                        err_next   = !IN_LAST;
                    end else begin
                        k_next = k_reg + 3'd1;
                    end
                end
            end
            ST_EVAL: begin
                if (wait_reg == 4'd0) begin
                    r_next     = R_IN;
                    state_next = ST_HOLD;
                end else begin
                    wait_next = wait_reg - 4'd1;
                end
            end
            ST_HOLD: begin
                R_VALID = 1'b1;
                if (R_READY) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    assign X_OUT = x_reg;
    assign R_OUT = r_reg;
    assign ERR   = err_reg;

endmodule

// File: tb/tb_x_200_mod_4051_loader.sv
// Bench for x_200_mod_4051_loader: a combinational reducer (MOD_LAT=0) and a two-stage
// pipelined reducer (MOD_LAT=2), checked against a word-wise software mod-4051 model.
module tb_x_200_mod_4051_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid, in_last, r_ready;
    int           sel;

    logic         a_in_ready, a_r_valid, a_err, b_in_ready, b_r_valid, b_err;
    logic [199:0] a_x, b_x;
    logic [11:0]  a_r_in, a_r_out, b_r_in, b_r_out, b_p1, b_p2;

    logic         in_ready, r_valid, err;
    logic [199:0] x_out;
    logic [11:0]  r_out;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    x_200_mod_4051_loader #(.MOD_LAT(0)) u_a (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid && sel == 0),
        .IN_LAST(in_last), .IN_READY(a_in_ready), .X_OUT(a_x), .R_IN(a_r_in),
        .R_OUT(a_r_out), .R_VALID(a_r_valid), .R_READY(r_ready && sel == 0), .ERR(a_err)
    );

    x_200_mod_4051_loader #(.MOD_LAT(2)) u_b (
        .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid && sel == 1),
        .IN_LAST(in_last), .IN_READY(b_in_ready), .X_OUT(b_x), .R_IN(b_r_in),
        .R_OUT(b_r_out), .R_VALID(b_r_valid), .R_READY(r_ready && sel == 1), .ERR(b_err)
    );

    // Reducers: combinational for u_a, two register stages for u_b.
    assign a_r_in = 12'(a_x % 200'd4051);
    always @(posedge clk) begin
        b_p1 <= 12'(b_x % 200'd4051);
        b_p2 <= b_p1;
    end
    assign b_r_in = b_p2;

    assign in_ready = (sel == 1) ? b_in_ready : a_in_ready;
    assign r_valid  = (sel == 1) ? b_r_valid  : a_r_valid;
    assign err      = (sel == 1) ? b_err      : a_err;
    assign x_out    = (sel == 1) ? b_x        : a_x;
    assign r_out    = (sel == 1) ? b_r_out    : a_r_out;

    always @(negedge clk) begin
        if (err) err_cnt++;
    end

    function automatic int unsigned ref_mod(input logic [31:0] w[7], input int n);
        longint unsigned r = 0;
        longint unsigned word;
        for (int i = 6; i >= 0; i--) begin
            word = (i < n) ? 64'(w[i]) : 64'd0;
            if (i == 6) word = word & 64'hFF;
            r = ((r << 32) + word) % 64'd4051;
        end
        return int'(r);
    endfunction

    function automatic logic [199:0] ref_x(input logic [31:0] w[7], input int n);
        logic [199:0] x = '0;
        for (int i = 0; i < n; i++) begin
            if (i < 6) x[32*i +: 32] = w[i];
            else       x[199:192]    = w[6][7:0];
        end
        return x;
    endfunction

    // Drives one word and returns #1 after the edge that accepted it.
    task automatic send_word(input logic [31:0] d, input logic last, input int idle);
        logic acc = 1'b0;
        in_valid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        in_data = d; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL word_accept: timeout, in_ready never high for word %h", d);
        end
    endtask

    task automatic send_op(input logic [31:0] w[7], input int n, input logic last, input int idle_max);
        for (int i = 0; i < n; i++)
            send_word(w[i], (i == n - 1) && last, $urandom_range(0, idle_max));
    endtask

    // cyc = cycle index (acceptance cycle = 0) at which R_VALID is first seen.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!r_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
        n_cmp++;
        if (!r_valid) begin
            n_bad++;
            $display("FAIL result_wait: timeout, r_valid=%b after %0d cycles, required 1", r_valid, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if (a_x !== '0 || b_x !== '0) begin
            n_bad++; $display("FAIL reset_x: got %h / %h, required 0", a_x, b_x);
        end
        n_cmp++;
        if ({a_r_out, b_r_out, a_r_valid, b_r_valid, a_err, b_err} !== '0) begin
            n_bad++; $display("FAIL reset_r: r_out=%0d/%0d r_valid=%b/%b err=%b/%b, required all 0",
                              a_r_out, b_r_out, a_r_valid, b_r_valid, a_err, b_err);
        end
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b/%b, required 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_single();
        int cyc;
        sel = 0; r_ready = 1'b1;
        exp_q.push_back(1);
        send_word(32'h1, 1'b1, 0);
        n_cmp++;
        if (x_out !== 200'd1) begin n_bad++; $display("FAIL single_x: got %h, required 1", x_out); end
        wait_result(cyc);
        n_cmp++;
        if (cyc !== 2) begin n_bad++; $display("FAIL single_latency: got %0d, required 2", cyc); end
        n_cmp++;
        if (r_out !== 12'(exp_q.pop_front())) begin
            n_bad++; $display("FAIL single_r: got %0d, required 1", r_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (r_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_pulse: r_valid=%b in_ready=%b, required 0/1", r_valid, in_ready);
        end
        $display("single: r_out=%0d latency=%0d", r_out, cyc);
    endtask

    task automatic test_values();
        logic [31:0] w[7];
        int          len[3]  = '{2, 1, 1};
        int unsigned want[3] = '{3923, 0, 4050};
        logic [31:0] w0[3]   = '{32'h0, 32'hFD3, 32'hFD2};
        int cyc;
        int e0 = err_cnt;
        sel = 0; r_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            w = '{default: 32'h0};
            w[0] = w0[t]; w[1] = 32'h1;
            exp_q.push_back(want[t]);
            send_op(w, len[t], 1'b1, 0);
            wait_result(cyc);
            n_cmp++;
            if (r_out !== 12'(exp_q.pop_front())) begin
                n_bad++; $display("FAIL value_%0d: got %0d, required %0d", t, r_out, want[t]);
            end
            $display("value %0d: r_out=%0d", t, r_out);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (err_cnt !== e0) begin n_bad++; $display("FAIL value_err: got %0d pulses, required 0", err_cnt - e0); end
    endtask

    task automatic test_overflow();
        logic [31:0] w[7] = '{default: 32'hFFFF_FFFF};
        int cyc;
        int e0 = err_cnt;
        sel = 0; r_ready = 1'b1;
        exp_q.push_back(ref_mod(w, 7));
        send_op(w, 7, 1'b0, 0);
        n_cmp++;
        if (x_out !== {200{1'b1}}) begin n_bad++; $display("FAIL overflow_x: got %h, required all ones", x_out); end
        wait_result(cyc);
        n_cmp++;
        if (r_out !== 12'(exp_q.pop_front())) begin
            n_bad++; $display("FAIL overflow_r: got %0d, required %0d", r_out, ref_mod(w, 7));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL overflow_err: got %0d pulses, required 1", err_cnt - e0); end
        $display("overflow: r_out=%0d err_pulses=%0d", r_out, err_cnt - e0);
    endtask

    task automatic test_hold();
        int cyc;
        logic [11:0] held;
        sel = 0; r_ready = 1'b0;
        exp_q.push_back(291);
        send_word(32'h123, 1'b1, 0);
        wait_result(cyc);
        n_cmp++;
        if (r_out !== 12'(exp_q.pop_front())) begin n_bad++; $display("FAIL hold_r: got %0d, required 291", r_out); end
        held = r_out;
        in_data = 32'hDEAD_BEEF; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (r_valid !== 1'b1 || r_out !== held || in_ready !== 1'b0 || x_out !== 200'h123) begin
                n_bad++; $display("FAIL hold_stable_%0d: r_valid=%b r_out=%0d in_ready=%b x=%h, required 1/%0d/0/123",
                                  i, r_valid, r_out, in_ready, x_out, held);
            end
        end
        r_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (r_valid !== 1'b0 || in_ready !== 1'b1 || x_out !== 200'h123) begin
            n_bad++; $display("FAIL hold_release: r_valid=%b in_ready=%b x=%h, required 0/1/123", r_valid, in_ready, x_out);
        end
        $display("hold: r_out=%0d released", held);
    endtask

    task automatic test_reset_mid();
        logic saw = 1'b0;
        int cyc;
        int e0;
        sel = 0; r_ready = 1'b1;
        send_word(32'h11, 1'b0, 0);
        send_word(32'h22, 1'b0, 0);
        send_word(32'h33, 1'b0, 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        e0 = err_cnt;
        n_cmp++;
        if (x_out !== '0 || r_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_load: x=%h r_valid=%b, required 0/0", x_out, r_valid);
        end
        exp_q.push_back(5);
        send_word(32'h5, 1'b1, 0);
        wait_result(cyc);
        n_cmp++;
        if (r_out !== 12'(exp_q.pop_front()) || cyc !== 2) begin
            n_bad++; $display("FAIL rst_next: r_out=%0d cyc=%0d, required 5/2", r_out, cyc);
        end
        @(posedge clk); #1;
        // Reset during EVAL on the pipelined instance must drop the result.
        sel = 1;
        send_word(32'h7, 1'b1, 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; saw = saw | r_valid; end
        n_cmp++;
        if (saw !== 1'b0 || err_cnt !== e0) begin
            n_bad++; $display("FAIL rst_eval: r_valid seen=%b err pulses=%0d, required 0/0", saw, err_cnt - e0);
        end
        $display("reset mid-op: discarded, next r_out ok");
    endtask

    task automatic test_pipelined();
        logic [31:0] w[7] = '{default: 32'h0};
        int cyc;
        sel = 1; r_ready = 1'b1;
        w[1] = 32'h1;
        exp_q.push_back(3923);
        send_op(w, 2, 1'b1, 0);
        wait_result(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_bad++; $display("FAIL pipe_latency: got %0d, required 4", cyc); end
        n_cmp++;
        if (r_out !== 12'(exp_q.pop_front())) begin n_bad++; $display("FAIL pipe_r: got %0d, required 3923", r_out); end
        $display("pipelined: r_out=%0d latency=%0d", r_out, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0]  w[7];
        logic [199:0] xe;
        int n, cyc, exp_err;
        int unsigned want;
        logic last;
        int e0 = err_cnt;
        int bad0 = n_bad;
        exp_err = 0;
        sel = 1;
        for (int op = 0; op < 200; op++) begin
            n = $urandom_range(1, 7);
            last = (n < 7) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!last) exp_err++;
            for (int i = 0; i < 7; i++) w[i] = $urandom;
            xe = ref_x(w, n);
            exp_q.push_back(ref_mod(w, n));
            r_ready = 1'b0;
            send_op(w, n, last, 2);
            n_cmp++;
            if (x_out !== xe) begin n_bad++; $display("FAIL rand_x_%0d: got %h, required %h", op, x_out, xe); end
            wait_result(cyc);
            want = exp_q.pop_front();
            n_cmp++;
            if (r_out !== 12'(want)) begin n_bad++; $display("FAIL rand_r_%0d: got %0d, required %0d", op, r_out, want); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            r_ready = 1'b1;
            @(posedge clk); #1;
            r_ready = 1'b0;
        end
        n_cmp++;
        if (err_cnt - e0 !== exp_err) begin
            n_bad++; $display("FAIL rand_err: got %0d pulses, required %0d", err_cnt - e0, exp_err);
        end
        $display("random: 200 operands, %0d new mismatches", n_bad - bad0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; r_ready = 1'b1; sel = 0;
        test_reset();
        test_single();
        test_values();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_pipelined();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
